// File: rtl/rocket_control_pkg.sv
// Shared constants, sprite addresses and the state encoding for the player rocket.
package rocket_control_pkg;

    localparam int DAC_WIDTH         = 8;
    localparam int SPRITE_ADDR_WIDTH = 10;

    localparam int Y_LAUNCH    = 16;
    localparam int Y_TOP       = 240;
    localparam int ROCKET_STEP = 4;
    localparam int HIT_RADIUS  = 4;

    localparam int DEF_EXPLODE_TIME  = 3;
    localparam int DEF_COOLDOWN_TIME = 2;

    localparam int ADR_ROCKET  = 0;
    localparam int ADR_EXPLODE = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLY      = 2'd1,
        EXPLODE  = 2'd2,
        COOLDOWN = 2'd3
    } rocket_state_t;

endpackage

// File: rtl/rocket_control_if.sv
// Rocket controller bus: game-side inputs and renderer/enemy-side outputs.
interface rocket_control_if
    import rocket_control_pkg::*;
#(
    parameter int OUT_WIDTH    = DAC_WIDTH,
    parameter int ADDRESSWIDTH = SPRITE_ADDR_WIDTH
) ();
    logic                    fire;
    logic [OUT_WIDTH-1:0]    xaim;
    logic                    speed_pulse;
    logic [OUT_WIDTH-1:0]    xenemy;
    logic [OUT_WIDTH-1:0]    yenemy;
    logic                    enemy_spawn;
    logic [OUT_WIDTH-1:0]    xrocket;
    logic [OUT_WIDTH-1:0]    yrocket;
    logic                    rocket_active;
    logic [ADDRESSWIDTH-1:0] adr_rocket;
    logic                    rockethit;
    logic                    ready;

    modport master (
        output fire, xaim, speed_pulse, xenemy, yenemy, enemy_spawn,
        input  xrocket, yrocket, rocket_active, adr_rocket, rockethit, ready
    );

    modport slave (
        input  fire, xaim, speed_pulse, xenemy, yenemy, enemy_spawn,
        output xrocket, yrocket, rocket_active, adr_rocket, rockethit, ready
    );
endinterface

// File: rtl/rocket_control_hit_detect.sv
// Combinational box-collision test: both unsigned axis distances within radius, gated by enable.
module rocket_hit_detect #(
    parameter int OUT_WIDTH  = 8,
    parameter int HIT_RADIUS = 4
) (
    input  logic                 i_enable,
    input  logic [OUT_WIDTH-1:0] i_xa,
    input  logic [OUT_WIDTH-1:0] i_ya,
    input  logic [OUT_WIDTH-1:0] i_xb,
    input  logic [OUT_WIDTH-1:0] i_yb,
    output logic                 o_hit
);
    localparam logic [OUT_WIDTH-1:0] RADIUS = OUT_WIDTH'(HIT_RADIUS);

    // max-min keeps the distance unsigned without any wrap
    function automatic logic [OUT_WIDTH-1:0] abs_diff(input logic [OUT_WIDTH-1:0] a,
                                                      input logic [OUT_WIDTH-1:0] b);
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

    logic [OUT_WIDTH-1:0] w_dx;
    logic [OUT_WIDTH-1:0] w_dy;

    assign w_dx  = abs_diff(i_xa, i_xb);
    assign w_dy  = abs_diff(i_ya, i_yb);
    assign o_hit = i_enable & (w_dx <= RADIUS) & (w_dy <= RADIUS);
endmodule

// File: rtl/rocket_control.sv
// Player rocket: launch at latched X, climb per speed_pulse, strobe rockethit on contact,
// then explosion and cooldown before re-arming.
module rocket_control
    import rocket_control_pkg::*;
#(
    parameter int OUT_WIDTH     = DAC_WIDTH,
    parameter int ADDRESSWIDTH  = SPRITE_ADDR_WIDTH,
    parameter int EXPLODE_TIME  = DEF_EXPLODE_TIME,
    parameter int COOLDOWN_TIME = DEF_COOLDOWN_TIME
) (
    input  logic             clk,
    input  logic             rst,
    rocket_control_if.slave  bus
);
    localparam int CNT_WIDTH = 8;

    rocket_state_t           r_state, w_state;
    logic [OUT_WIDTH-1:0]    r_x, w_x, r_y, w_y;
    logic                    r_active, w_active;
    logic                    r_hit, w_hit;
    logic                    r_ready, w_ready;
    logic [ADDRESSWIDTH-1:0] r_adr, w_adr;
    logic [CNT_WIDTH-1:0]    r_cnt, w_cnt;

    logic                    w_hit_en;
    logic                    w_hit_det;
    logic [OUT_WIDTH:0]      w_y_step;
    logic [CNT_WIDTH-1:0]    w_cnt_inc;
    logic                    w_explode_done;
    logic                    w_cooldown_done;

    assign w_hit_en        = (r_state == FLY) & bus.enemy_spawn;
    assign w_y_step        = {1'b0, r_y} + (OUT_WIDTH+1)'(ROCKET_STEP);
    assign w_cnt_inc       = r_cnt + CNT_WIDTH'(1);
    assign w_explode_done  = 32'(w_cnt_inc) >= EXPLODE_TIME;
    assign w_cooldown_done = 32'(w_cnt_inc) >= COOLDOWN_TIME;

    rocket_hit_detect #(
        .OUT_WIDTH  (OUT_WIDTH),
        .HIT_RADIUS (HIT_RADIUS)
    ) u_hit_detect (
        .i_enable (w_hit_en),
        .i_xa     (r_x),
        .i_ya     (r_y),
        .i_xb     (bus.xenemy),
        .i_yb     (bus.yenemy),
        .o_hit    (w_hit_det)
    );

    // Next-state and next-output decode; hit has priority over motion in FLY
    always_comb begin
        w_state  = r_state;
        w_x      = r_x;
        w_y      = r_y;
        w_active = r_active;
        w_hit    = 1'b0;
        w_ready  = r_ready;
        w_adr    = r_adr;
        w_cnt    = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.fire) begin
                    w_state  = FLY;
                    w_x      = bus.xaim;
                    w_y      = OUT_WIDTH'(Y_LAUNCH);
                    w_active = 1'b1;
                    w_ready  = 1'b0;
                    w_adr    = ADDRESSWIDTH'(ADR_ROCKET);
                    w_cnt    = '0;
                end else begin
                    w_ready  = 1'b1;
                end
            end
            FLY: begin
                if (w_hit_det) begin
                    w_state = EXPLODE;
                    w_hit   = 1'b1;
                    w_adr   = ADDRESSWIDTH'(ADR_EXPLODE);
                    w_cnt   = '0;
                end else if (bus.speed_pulse) begin
                    if (w_y_step >= (OUT_WIDTH+1)'(Y_TOP)) begin
                        w_state  = COOLDOWN;
                        w_y      = OUT_WIDTH'(Y_TOP);
                        w_active = 1'b0;
                        w_cnt    = '0;
                    end else begin
                        w_y      = w_y_step[OUT_WIDTH-1:0];
                    end
                end else begin
                    w_state = FLY;
                end
            end
            EXPLODE: begin
                if (bus.speed_pulse) begin
                    if (w_explode_done) begin
                        w_state  = COOLDOWN;
                        w_active = 1'b0;
                        w_adr    = ADDRESSWIDTH'(ADR_ROCKET);
                        w_cnt    = '0;
                    end else begin
                        w_cnt    = w_cnt_inc;
                    end
                end else begin
                    w_cnt = r_cnt;
                end
            end
            COOLDOWN: begin
                if (COOLDOWN_TIME == 0) begin
                    w_state = IDLE;
                    w_ready = 1'b1;
                    w_cnt   = '0;
                end else if (bus.speed_pulse) begin
                    if (w_cooldown_done) begin
                        w_state = IDLE;
                        w_ready = 1'b1;
                        w_cnt   = '0;
                    end else begin
                        w_cnt   = w_cnt_inc;
                    end
                end else begin
                    w_cnt = r_cnt;
                end
            end
            default: begin
                w_state  = IDLE;
                w_active = 1'b0;
                w_ready  = 1'b1;
                w_adr    = ADDRESSWIDTH'(ADR_ROCKET);
                w_cnt    = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_active <= 1'b0;
            r_hit    <= 1'b0;
            r_ready  <= 1'b1;
            r_adr    <= ADDRESSWIDTH'(ADR_ROCKET);
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state;
            r_x      <= w_x;
            r_y      <= w_y;
            r_active <= w_active;
            r_hit    <= w_hit;
            r_ready  <= w_ready;
            r_adr    <= w_adr;
            r_cnt    <= w_cnt;
        end
    end

    assign bus.xrocket       = r_x;
    assign bus.yrocket       = r_y;
    assign bus.rocket_active = r_active;
    assign bus.adr_rocket    = r_adr;
    assign bus.rockethit     = r_hit;
    assign bus.ready         = r_ready;
endmodule

// File: tb/tb_rocket_control.sv
// Directed bench for rocket_control: launch, climb, hit, miss, fire lockout and mid-flight reset.
module tb_rocket_control;
    import rocket_control_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   hit_seen = 0;

    always #5 clk = ~clk;

    rocket_control_if bus ();

    rocket_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if (bus.rockethit === 1'b1) hit_seen++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            bus.speed_pulse = 1'b1;
            tick();
            bus.speed_pulse = 1'b0;
        end
    endtask

    task automatic launch(input logic [7:0] x);
        bus.fire = 1'b1;
        bus.xaim = x;
        tick();
        bus.fire = 1'b0;
    endtask

    initial begin
        bus.fire        = 1'b0;
        bus.xaim        = 8'd0;
        bus.speed_pulse = 1'b0;
        bus.xenemy      = 8'd0;
        bus.yenemy      = 8'd0;
        bus.enemy_spawn = 1'b0;

        // reset values
        rst = 1'b1;
        tick();
        tick();
        check("rst_x", 32'(bus.xrocket), 32'd0);
        check("rst_y", 32'(bus.yrocket), 32'd0);
        check("rst_active", 32'(bus.rocket_active), 32'd0);
        check("rst_hit", 32'(bus.rockethit), 32'd0);
        check("rst_adr", 32'(bus.adr_rocket), 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd1);
        rst = 1'b0;
        tick();

        // launch with simultaneous pulse (ignored), climb, then miss far enemy
        bus.xenemy = 8'd200; bus.yenemy = 8'd120; bus.enemy_spawn = 1'b1;
        bus.fire = 1'b1; bus.xaim = 8'd100; bus.speed_pulse = 1'b1;
        tick();
        bus.fire = 1'b0; bus.speed_pulse = 1'b0;
        check("l1_y", 32'(bus.yrocket), 32'd16);
        check("l1_x", 32'(bus.xrocket), 32'd100);
        check("l1_ready", 32'(bus.ready), 32'd0);
        check("l1_active", 32'(bus.rocket_active), 32'd1);
        pulse(3);
        check("l1_y3", 32'(bus.yrocket), 32'd28);
        check("l1_x3", 32'(bus.xrocket), 32'd100);
        pulse(52);
        check("l1_y55", 32'(bus.yrocket), 32'd236);
        check("l1_active55", 32'(bus.rocket_active), 32'd1);
        pulse(1);
        check("l1_ytop", 32'(bus.yrocket), 32'd240);
        check("l1_retire", 32'(bus.rocket_active), 32'd0);
        check("l1_nohit", 32'(hit_seen), 32'd0);
        pulse(1);
        check("l1_cool1", 32'(bus.ready), 32'd0);
        pulse(1);
        check("l1_rearm", 32'(bus.ready), 32'd1);

        // enemy in range but not spawned
        bus.xenemy = 8'd104; bus.yenemy = 8'd120; bus.enemy_spawn = 1'b0;
        launch(8'd100);
        pulse(56);
        check("ns_ytop", 32'(bus.yrocket), 32'd240);
        check("ns_retire", 32'(bus.rocket_active), 32'd0);
        check("ns_nohit", 32'(hit_seen), 32'd0);
        pulse(2);
        check("ns_rearm", 32'(bus.ready), 32'd1);

        // spawned enemy one past the radius
        bus.xenemy = 8'd105; bus.enemy_spawn = 1'b1;
        launch(8'd100);
        pulse(56);
        check("r5_ytop", 32'(bus.yrocket), 32'd240);
        check("r5_nohit", 32'(hit_seen), 32'd0);
        pulse(2);
        check("r5_rearm", 32'(bus.ready), 32'd1);

        // hit at (100,120) with fire held high throughout
        bus.xenemy = 8'd100; bus.yenemy = 8'd120; bus.enemy_spawn = 1'b1;
        bus.fire = 1'b1; bus.xaim = 8'd100;
        tick();
        bus.xaim = 8'd50;
        pulse(24);
        check("h_y24", 32'(bus.yrocket), 32'd112);
        pulse(1);
        check("h_y25", 32'(bus.yrocket), 32'd116);
        check("h_prehit", 32'(bus.rockethit), 32'd0);
        tick();
        check("h_hit", 32'(bus.rockethit), 32'd1);
        check("h_adr", 32'(bus.adr_rocket), 32'd64);
        check("h_xfix", 32'(bus.xrocket), 32'd100);
        check("h_yfix", 32'(bus.yrocket), 32'd116);
        tick();
        check("h_hit1cyc", 32'(bus.rockethit), 32'd0);
        pulse(2);
        check("h_exp2_active", 32'(bus.rocket_active), 32'd1);
        pulse(1);
        check("h_exp3_active", 32'(bus.rocket_active), 32'd0);
        check("h_exp3_adr", 32'(bus.adr_rocket), 32'd0);
        check("h_exp3_ready", 32'(bus.ready), 32'd0);
        pulse(1);
        check("h_cool1", 32'(bus.ready), 32'd0);
        pulse(1);
        check("h_rearm", 32'(bus.ready), 32'd1);
        check("h_xhold", 32'(bus.xrocket), 32'd100);
        check("h_hitcount", 32'(hit_seen), 32'd1);
        tick();
        bus.fire = 1'b0;
        check("h_relaunch_x", 32'(bus.xrocket), 32'd50);
        check("h_relaunch_y", 32'(bus.yrocket), 32'd16);
        check("h_relaunch_rdy", 32'(bus.ready), 32'd0);

        // reset mid-flight at y=60
        bus.enemy_spawn = 1'b0;
        pulse(11);
        check("m_y60", 32'(bus.yrocket), 32'd60);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("m_x", 32'(bus.xrocket), 32'd0);
        check("m_y", 32'(bus.yrocket), 32'd0);
        check("m_active", 32'(bus.rocket_active), 32'd0);
        check("m_hit", 32'(bus.rockethit), 32'd0);
        check("m_adr", 32'(bus.adr_rocket), 32'd0);
        check("m_ready", 32'(bus.ready), 32'd1);
        launch(8'd30);
        check("m_launch_y", 32'(bus.yrocket), 32'd16);
        check("m_launch_x", 32'(bus.xrocket), 32'd30);
        check("m_hitcount", 32'(hit_seen), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rocket_control.md
Name: rocket_control

Overview:
- Player-rocket controller; the sender of the `rockethit` signal that each enemy_control instance consumes.
- On a fire request it launches a rocket from the base at a latched aim X and climbs it one step per `speed_pulse` toward the top of the screen.
- It compares the rocket position against the enemy position every clock and emits a one-cycle `rockethit` on contact.
- It then plays an explosion sprite, observes a cooldown and re-arms. Its coordinate/address outputs feed the vector renderer alongside the enemy outputs.

Parameters:
- OUT_WIDTH, 8, coordinate width (DAC_WIDTH).
- ADDRESSWIDTH, 10, sprite ROM address width.
- Y_LAUNCH, 16, rocket start Y.
- Y_TOP, 240, Y at which an unhit rocket is retired.
- STEP, 4, Y increment per speed_pulse.
- HIT_RADIUS, 4, max abs X and abs Y distance counted as a hit (inclusive).
- EXPLODE_TIME, 3, speed_pulses spent in explosion.
- COOLDOWN_TIME, 2, speed_pulses before re-arm.
- ADR_ROCKET, 0, sprite address of the rocket.
- ADR_EXPLODE, 64, sprite address of the explosion.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- fire  in  1  launch request; level or pulse, sampled only in IDLE.
- xaim  in  OUT_WIDTH  launch X, latched on an accepted fire.
- speed_pulse  in  1  one-cycle motion tick (timer_cluster).
- xenemy  in  OUT_WIDTH  enemy X.
- yenemy  in  OUT_WIDTH  enemy Y.
- enemy_spawn  in  1  enemy alive/visible (enemy_control spawn).
- xrocket  out  OUT_WIDTH  rocket/explosion X.
- yrocket  out  OUT_WIDTH  rocket/explosion Y.
- rocket_active  out  1  draw enable (FLY or EXPLODE).
- adr_rocket  out  ADDRESSWIDTH  sprite address.
- rockethit  out  1  one-cycle hit strobe to enemy_control.
- ready  out  1  high in IDLE (fire will be accepted).

Behaviour:
- Reset (sync, active-high, overrides all):
  - State IDLE.
  - xrocket=0, yrocket=0, rocket_active=0, rockethit=0, adr_rocket=ADR_ROCKET, ready=1.
  - Pulse counter cleared.
  - Reset asserted mid-flight or mid-explosion aborts with no rockethit.
- Registered outputs: all outputs are registered.
- IDLE:
  - If fire=1, next cycle: state FLY, xrocket<=xaim, yrocket<=Y_LAUNCH, rocket_active<=1, ready<=0, adr_rocket<=ADR_ROCKET.
  - speed_pulse in the same cycle as fire is ignored; the first move is on the next speed_pulse.
- FLY:
  - Hit condition each clk, evaluated on registered xrocket/yrocket: enemy_spawn=1 AND abs(xrocket-xenemy)<=HIT_RADIUS AND abs(yrocket-yenemy)<=HIT_RADIUS.
  - Distances are computed unsigned via max-min; no wrap.
  - On hit, next cycle: rockethit=1 for exactly one clk, state EXPLODE, adr_rocket<=ADR_EXPLODE, position frozen, counter cleared.
  - Otherwise, on speed_pulse: if yrocket+STEP >= Y_TOP then yrocket<=Y_TOP and state COOLDOWN with rocket_active<=0 (miss); else yrocket<=yrocket+STEP.
  - The addition is done at OUT_WIDTH+1 bits to avoid overflow.
  - Hit and speed_pulse in the same cycle: hit wins, no move.
  - Hit on the cycle yrocket==Y_TOP is impossible; the rocket has already left FLY.
- EXPLODE:
  - Counts speed_pulses.
  - On the EXPLODE_TIME-th pulse: state COOLDOWN, rocket_active<=0, adr_rocket<=ADR_ROCKET, counter cleared.
  - Hit logic is disabled, so rockethit is never repeated.
- COOLDOWN:
  - Counts speed_pulses.
  - On the COOLDOWN_TIME-th pulse: state IDLE, ready<=1.
  - fire is ignored throughout.
  - COOLDOWN_TIME=0 returns to IDLE on the next clk.
- Invariants:
  - rockethit is high only on the FLY->EXPLODE transition cycle.
  - At most one rocket in flight.

Decomposition:
- Shared package additions:
  - vector_pkg: Y_LAUNCH, Y_TOP, ROCKET_STEP, HIT_RADIUS.
  - img_pkg: ADR_ROCKET, ADR_EXPLODE.
  - Shared package (state enum): rocket_state_t {IDLE, FLY, EXPLODE, COOLDOWN}.
- Sub-module `rocket_hit_detect`: purely combinational, two abs-distance comparators plus the enabling AND, parameterised on OUT_WIDTH and HIT_RADIUS. It is reusable for bomb/base collision later.

Test Plan:
- Reset, then fire=1 with xaim=100, then 3 speed_pulses. Expected: yrocket 16->28, xrocket=100, ready=0, rocket_active=1.
- Enemy at (100,120) with enemy_spawn=1, fire with xaim=100. Expected: after the 25th speed_pulse yrocket=116; the next clk has rockethit=1 for one cycle and adr_rocket=ADR_EXPLODE. After 3 more pulses rocket_active=0; after 2 more ready=1.
- Enemy at (200,120), xaim=100. Expected: after 56 pulses yrocket=240, state goes to COOLDOWN, rocket_active=0, rockethit never asserted.
- Enemy at (104,120) but enemy_spawn=0. Expected: no rockethit, rocket retires at Y_TOP. Repeat with enemy_spawn=1 and xenemy=105: no hit, because 5 > HIT_RADIUS.
- fire held high during FLY/EXPLODE/COOLDOWN. Expected: ignored, xrocket unchanged when xaim changes; a new launch occurs only once ready=1.
- rst pulsed while yrocket=60 in FLY. Expected: next clk all outputs at reset values, rockethit stays 0, and a subsequent fire launches at Y_LAUNCH=16.
